// File: rtl/core_sequencer.sv
// core_sequencer
// Multi-cycle control FSM for an RV32I core. Each instruction is stepped
// through FETCH -> DECODE (DEC_LAT cycles) -> EXEC -> [MEM] -> WB, and an
// illegal one-hot decode parks the sequencer in TRAP until reset.
//
// Ports
//   i_clk           core clock, all logic on posedge
//   i_rst_n         synchronous active-low reset
//   o_imem_req      fetch request, high for the whole FETCH state
//   i_imem_ready    fetch data valid this cycle
//   o_ir_load       strobe: capture fetched word into the IR
//   i_instr_bus     38-bit one-hot decoded instruction
//   i_rd_valid      decoded instruction writes rd
//   i_branch_taken  ALU compare result, sampled in EXEC only
//   o_dmem_req      data memory request, high for the whole MEM state
//   o_dmem_we       data memory write enable (stores)
//   i_dmem_ready    data access complete this cycle
//   o_rf_we         register file write strobe (WB only)
//   o_pc_we         PC update strobe (WB only)
//   o_pc_sel        00 PC+4, 01 PC+imm, 10 rs1+imm
//   o_halt          sticky illegal-instruction halt
//   o_state         FSM state (0 FETCH .. 5 TRAP)
//   o_instret       retired instruction counter
module core_sequencer #(
  parameter int DEC_LAT = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  input  logic        i_imem_ready,
  output logic        o_ir_load,
  input  logic [37:0] i_instr_bus,
  input  logic        i_rd_valid,
  input  logic        i_branch_taken,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  input  logic        i_dmem_ready,
  output logic        o_rf_we,
  output logic        o_pc_we,
  output logic [1:0]  o_pc_sel,
  output logic        o_halt,
  output logic [2:0]  o_state,
  output logic [31:0] o_instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  // Counter just wide enough to reach DEC_LAT-1; it may wrap on the exit
  // cycle, which is harmless because DECODE is left on that cycle.
  localparam int CW = (DEC_LAT > 1) ? $clog2(DEC_LAT) : 1;
  localparam logic [CW-1:0] DEC_LAST = CW'(DEC_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_dec_cnt;
  logic          r_is_ld;
  logic          r_is_st;
  logic          r_is_br;
  logic          r_is_jal;
  logic          r_is_jalr;
  logic          r_wr;
  logic          r_taken;
  logic [31:0]   r_instret;
  logic          w_dec_done;
  logic          w_legal;

  // Legal decode: bit 37 clear and exactly one of bits 36..0 set.
  function automatic logic f_legal(input logic [37:0] bus);
    logic [36:0] low;
    low = bus[36:0];
    return (bus[37] == 1'b0) && (low != 37'd0) &&
           ((low & (low - 37'd1)) == 37'd0);
  endfunction

  assign w_dec_done = (r_dec_cnt == DEC_LAST);
  assign w_legal    = f_legal(i_instr_bus);
  assign o_state    = r_state;
  assign o_instret  = r_instret;

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and state-decoded strobes.
  always_comb begin
    w_state_nxt = r_state;
    o_imem_req  = 1'b0;
    o_ir_load   = 1'b0;
    o_dmem_req  = 1'b0;
    o_dmem_we   = 1'b0;
    o_rf_we     = 1'b0;
    o_pc_we     = 1'b0;
    o_pc_sel    = 2'b00;
    o_halt      = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_imem_req = 1'b1;
        o_ir_load  = i_imem_ready;
        if (i_imem_ready) begin
          w_state_nxt = S_DECODE;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_DECODE: begin
        if (w_dec_done) begin
          w_state_nxt = w_legal ? S_EXEC : S_TRAP;
        end else begin
          w_state_nxt = S_DECODE;
        end
      end
      S_EXEC: begin
        w_state_nxt = (r_is_ld | r_is_st) ? S_MEM : S_WB;
      end
      S_MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = r_is_st;
        if (i_dmem_ready) begin
          w_state_nxt = S_WB;
        end else begin
          w_state_nxt = S_MEM;
        end
      end
      S_WB: begin
        o_rf_we     = r_wr;
        o_pc_we     = 1'b1;
        // jalr has priority; a taken branch and jal share the PC+imm path.
        if (r_is_jalr) begin
          o_pc_sel = 2'b10;
        end else if (r_is_jal | r_taken) begin
          o_pc_sel = 2'b01;
        end else begin
          o_pc_sel = 2'b00;
        end
        w_state_nxt = S_FETCH;
      end
      S_TRAP: begin
        o_halt      = 1'b1;
        w_state_nxt = S_TRAP;
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  // Decode counter, instruction class latches and retire counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_dec_cnt <= '0;
      r_is_ld   <= 1'b0;
      r_is_st   <= 1'b0;
      r_is_br   <= 1'b0;
      r_is_jal  <= 1'b0;
      r_is_jalr <= 1'b0;
      r_wr      <= 1'b0;
      r_taken   <= 1'b0;
      r_instret <= 32'd0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (i_imem_ready) begin
            r_dec_cnt <= '0;
          end else begin
            r_dec_cnt <= r_dec_cnt;
          end
        end
        S_DECODE: begin
          r_dec_cnt <= r_dec_cnt + CNT_ONE;
          if (w_dec_done && w_legal) begin
            r_is_ld   <= |i_instr_bus[23:19];
            r_is_st   <= |i_instr_bus[26:24];
            r_is_br   <= |i_instr_bus[32:27];
            r_is_jal  <= i_instr_bus[33];
            r_is_jalr <= i_instr_bus[34];
            r_wr      <= i_rd_valid & ~(|i_instr_bus[26:24]) & ~(|i_instr_bus[32:27]);
          end else begin
            r_is_ld   <= r_is_ld;
          end
        end
        S_EXEC: begin
          r_taken <= i_branch_taken & r_is_br;
        end
        S_WB: begin
          r_instret <= r_instret + 32'd1;
        end
        default: begin
          r_dec_cnt <= r_dec_cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer
// Randomized scoreboard bench for core_sequencer. The driver issues one
// instruction at a time, computes the expected WB response from the
// instruction class rules and pushes it into a queue; a forked monitor pops
// and compares whenever the DUT shows its WB strobe.
module tb_core_sequencer;
  localparam int DEC_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ready, ir_load;
  logic [37:0] instr_bus;
  logic        rd_valid, branch_taken;
  logic        dmem_req, dmem_we, dmem_ready;
  logic        rf_we, pc_we, halt;
  logic [1:0]  pc_sel;
  logic [2:0]  state;
  logic [31:0] instret;

  always #5 clk = ~clk;

  core_sequencer #(.DEC_LAT(DEC_LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_imem_req(imem_req), .i_imem_ready(imem_ready),
    .o_ir_load(ir_load), .i_instr_bus(instr_bus), .i_rd_valid(rd_valid),
    .i_branch_taken(branch_taken), .o_dmem_req(dmem_req), .o_dmem_we(dmem_we),
    .i_dmem_ready(dmem_ready), .o_rf_we(rf_we), .o_pc_we(pc_we), .o_pc_sel(pc_sel),
    .o_halt(halt), .o_state(state), .o_instret(instret)
  );

  typedef struct {
    logic        rf_we;
    logic [1:0]  pc_sel;
    logic        we;
    int          lat;
    int          mcycles;
    logic [31:0] instret;
  } exp_t;

  exp_t        exp_q[$];
  int          n_total = 0;
  int          n_bad   = 0;
  int          cyc     = 0;
  int          t_fetch = 0;
  int          mem_seen = 0;
  logic [31:0] model_instret = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, pops one expectation per WB.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        mem_seen = 0;
      end else begin
        if (ir_load) t_fetch = cyc;
        if (dmem_req) begin
          mem_seen++;
          chk("mem_has_expectation", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) chk("dmem_we", 64'(dmem_we), 64'(exp_q[0].we));
        end
        if (pc_we) begin
          chk("wb_has_expectation", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wb_state", 64'(state), 64'd4);
            chk("wb_rf_we", 64'(rf_we), 64'(e.rf_we));
            chk("wb_pc_sel", 64'(pc_sel), 64'(e.pc_sel));
            chk("wb_latency", 64'(cyc - t_fetch), 64'(e.lat));
            chk("mem_cycles", 64'(mem_seen), 64'(e.mcycles));
            chk("instret_at_wb", 64'(instret), 64'(e.instret));
          end
          mem_seen = 0;
        end
      end
    end
  endtask

  task automatic wait_imem_req(input string name);
    int k = 0;
    while (!imem_req && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk(name, 64'(imem_req), 64'd1);
  endtask

  task automatic wait_dmem_req();
    int k = 0;
    while (!dmem_req && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("dmem_req_seen", 64'(dmem_req), 64'd1);
  endtask

  // Fetch handshake after fw idle cycles; dmem_ready noise must be ignored.
  task automatic fetch(input int fw);
    wait_imem_req("fetch_req_seen");
    for (int i = 0; i < fw; i++) begin
      dmem_ready = 1'($urandom_range(1, 0));
      @(posedge clk); #1;
    end
    dmem_ready = 1'b0;
    imem_ready = 1'b1;
    @(posedge clk); #1;
    imem_ready = 1'b0;
  endtask

  // Issue one legal instruction; expectation derived from the class rules.
  task automatic run_instr(input logic [37:0] bus, input logic rd, input logic tk,
                           input int fw, input int mw);
    int   b;
    logic ld, st, br, jal, jalr;
    exp_t e;
    b = 0;
    for (int i = 0; i < 37; i++) if (bus[i]) b = i;
    ld   = (b >= 19 && b <= 23);
    st   = (b >= 24 && b <= 26);
    br   = (b >= 27 && b <= 32);
    jal  = (b == 33);
    jalr = (b == 34);
    e.rf_we   = rd && !st && !br;
    e.pc_sel  = jalr ? 2'd2 : ((jal || (br && tk)) ? 2'd1 : 2'd0);
    e.we      = st;
    e.mcycles = (ld || st) ? mw + 1 : 0;
    e.lat     = DEC_LAT + 2 + e.mcycles;
    e.instret = model_instret;
    model_instret = model_instret + 32'd1;
    exp_q.push_back(e);
    instr_bus    = bus;
    rd_valid     = rd;
    branch_taken = tk;
    fetch(fw);
    if (ld || st) begin
      wait_dmem_req();
      repeat (mw) begin @(posedge clk); #1; end
      dmem_ready = 1'b1;
      @(posedge clk); #1;
      dmem_ready = 1'b0;
    end
    wait_imem_req("back_to_fetch");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    exp_q.delete();
    model_instret = 32'd0;
  endtask

  task automatic check_trap(input string name, input logic [37:0] bus);
    logic ok;
    instr_bus = bus;
    rd_valid  = 1'b1;
    fetch(0);
    repeat (DEC_LAT) begin @(posedge clk); #1; end
    chk({name, "_state"}, 64'(state), 64'd5);
    chk({name, "_halt"}, 64'(halt), 64'd1);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      imem_ready = 1'($urandom_range(1, 0));
      dmem_ready = 1'($urandom_range(1, 0));
      @(posedge clk); #1;
      if (!(halt && state == 3'd5 && !imem_req && !ir_load && !dmem_req && !dmem_we &&
            !rf_we && !pc_we && instret == model_instret)) ok = 1'b0;
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    chk({name, "_held20"}, 64'(ok), 64'd1);
    do_reset();
    chk({name, "_reset_state"}, 64'(state), 64'd0);
    chk({name, "_reset_halt"}, 64'(halt), 64'd0);
  endtask

  initial begin
    logic [37:0] bus;
    exp_t        e;
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [37:0] bus;
    exp_t        e;
    rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    instr_bus = '0; rd_valid = 1'b0; branch_taken = 1'b0;
    fork monitor(); join_none
    do_reset();

    chk("rst_state", 64'(state), 64'd0);
    chk("rst_imem_req", 64'(imem_req), 64'd1);
    chk("rst_ir_load", 64'(ir_load), 64'd0);
    chk("rst_dmem_req", 64'(dmem_req), 64'd0);
    chk("rst_rf_pc_we", 64'({rf_we, pc_we, dmem_we}), 64'd0);
    chk("rst_pc_sel", 64'(pc_sel), 64'd0);
    chk("rst_halt", 64'(halt), 64'd0);
    chk("rst_instret", 64'(instret), 64'd0);

    // Directed: addi, lw (3 wait), sw, beq taken/not, jalr, jal.
    bus = '0; bus[10] = 1'b1; run_instr(bus, 1'b1, 1'b0, 0, 0);
    chk("addi_instret", 64'(instret), 64'd1);
    bus = '0; bus[19] = 1'b1; run_instr(bus, 1'b1, 1'b0, 0, 3);
    bus = '0; bus[24] = 1'b1; run_instr(bus, 1'b1, 1'b1, 1, 0);
    bus = '0; bus[27] = 1'b1; run_instr(bus, 1'b1, 1'b1, 0, 0);
    bus = '0; bus[27] = 1'b1; run_instr(bus, 1'b1, 1'b0, 0, 0);
    bus = '0; bus[34] = 1'b1; run_instr(bus, 1'b1, 1'b1, 0, 0);
    bus = '0; bus[33] = 1'b1; run_instr(bus, 1'b0, 1'b0, 2, 0);

    // Randomized legal instructions.
    for (int n = 0; n < 60; n++) begin
      bus = '0;
      bus[$urandom_range(36, 0)] = 1'b1;
      run_instr(bus, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                int'($urandom_range(3, 0)), int'($urandom_range(4, 0)));
    end
    chk("instret_count", 64'(instret), 64'(model_instret));

    // Retire counter wrap.
    force dut.r_instret = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.r_instret;
    model_instret = 32'hFFFF_FFFF;
    chk("instret_preset", 64'(instret), 64'hFFFF_FFFF);
    bus = '0; bus[12] = 1'b1; run_instr(bus, 1'b1, 1'b0, 0, 0);
    chk("instret_wrap", 64'(instret), 64'd0);

    // Illegal encodings.
    bus = '0;                               check_trap("trap_zero", bus);
    bus = '0; bus[0] = 1'b1; bus[10] = 1'b1; check_trap("trap_multi", bus);
    bus = '0; bus[37] = 1'b1;               check_trap("trap_bit37", bus);

    // Reset while in MEM drops the request and discards the load.
    bus = '0; bus[19] = 1'b1;
    e.rf_we = 1'b1; e.pc_sel = 2'd0; e.we = 1'b0; e.lat = 0; e.mcycles = 0; e.instret = 32'd0;
    exp_q.push_back(e);
    instr_bus = bus; rd_valid = 1'b1;
    fetch(0);
    wait_dmem_req();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midmem_rst_dmem_req", 64'(dmem_req), 64'd0);
    chk("midmem_rst_state", 64'(state), 64'd0);
    rst_n = 1'b1;
    exp_q.delete();
    model_instret = 32'd0;
    chk("midmem_rst_instret", 64'(instret), 64'd0);
    bus = '0; bus[22] = 1'b1; run_instr(bus, 1'b1, 1'b0, 0, 1);
    chk("post_rst_instret", 64'(instret), 64'd1);

    repeat (5) @(posedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
